seg_scan_driver: RTL

SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

---
 rtl/seg_scan_driver_pkg.sv | 29 ++
 rtl/seg_scan_driver_hex_decode.sv | 31 +++
 rtl/seg_scan_driver.sv | 136 +++++++++++++
 3 files changed

// File: rtl/seg_scan_driver_pkg.sv
// Shared constants for the multiplexed seven-segment scan driver:
// active-low hex glyphs, the blank pattern and the digit-index width helper.
package seg_scan_driver_pkg;

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Bit order is g..a, so a cleared bit lights that segment.
  localparam logic [6:0] HEX_0 = 7'h40;
  localparam logic [6:0] HEX_1 = 7'h79;
  localparam logic [6:0] HEX_2 = 7'h24;
  localparam logic [6:0] HEX_3 = 7'h30;
  localparam logic [6:0] HEX_4 = 7'h19;
  localparam logic [6:0] HEX_5 = 7'h12;
  localparam logic [6:0] HEX_6 = 7'h02;
  localparam logic [6:0] HEX_7 = 7'h78;
  localparam logic [6:0] HEX_8 = 7'h00;
  localparam logic [6:0] HEX_9 = 7'h10;
  localparam logic [6:0] HEX_A = 7'h08;
  localparam logic [6:0] HEX_B = 7'h03;
  localparam logic [6:0] HEX_C = 7'h46;
  localparam logic [6:0] HEX_D = 7'h21;
  localparam logic [6:0] HEX_E = 7'h06;
  localparam logic [6:0] HEX_F = 7'h0E;

  function automatic int idx_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/seg_scan_driver_hex_decode.sv
// Combinational nibble to active-low seven-segment glyph (0-9, A-F).
module seg_hex_decode
  import seg_scan_driver_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] pattern
);

  always_comb begin
    pattern = HEX_0;
    case (nibble)
      4'h0: pattern = HEX_0;
      4'h1: pattern = HEX_1;
      4'h2: pattern = HEX_2;
      4'h3: pattern = HEX_3;
      4'h4: pattern = HEX_4;
      4'h5: pattern = HEX_5;
      4'h6: pattern = HEX_6;
      4'h7: pattern = HEX_7;
      4'h8: pattern = HEX_8;
      4'h9: pattern = HEX_9;
      4'hA: pattern = HEX_A;
      4'hB: pattern = HEX_B;
      4'hC: pattern = HEX_C;
      4'hD: pattern = HEX_D;
      4'hE: pattern = HEX_E;
      4'hF: pattern = HEX_F;
    endcase
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed seven-segment driver with double-buffered (tear-free) digit
// data, leading-zero suppression and per-slot PWM brightness.
module seg_scan_driver
  import seg_scan_driver_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int CLK_DIV    = 100000,
  parameter int BRIGHT_W   = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] data_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  input  logic                    lz_en,
  input  logic                    load,
  input  logic [BRIGHT_W-1:0]     brightness,
  output logic [7:0]              seg_out,
  output logic [NUM_DIGITS-1:0]   an_out,
  output logic                    frame_done,
  output logic                    pend_out
);

  localparam int IDX_W = idx_width(NUM_DIGITS);
  localparam int CNT_W = $clog2(CLK_DIV);
  localparam int DW    = 4 * NUM_DIGITS;
  localparam int PW    = BRIGHT_W + 33;

  logic [CNT_W-1:0]      cnt;
  logic [IDX_W-1:0]      idx;
  logic                  tick;
  logic                  wrap;

  logic [DW-1:0]         pend_data, act_data;
  logic [NUM_DIGITS-1:0] pend_dp, act_dp;
  logic [NUM_DIGITS-1:0] pend_blank, act_blank;
  logic                  pend_lz, act_lz;
  logic                  pend;

  logic [3:0]            nib;
  logic [6:0]            hex_pat;
  logic                  dp_bit, blank_bit, any_nz, dark, lit_on;
  logic [PW-1:0]         duty_thr;
  logic [7:0]            seg_nxt, seg_p1;
  logic [NUM_DIGITS-1:0] an_nxt, an_p1;

  assign tick = (cnt == CNT_W'(CLK_DIV - 1));
  assign wrap = tick && (idx == IDX_W'(NUM_DIGITS - 1));

  // Stage p0: scan counters and the pending/active double buffer
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      idx        <= '0;
      frame_done <= 1'b0;
      pend       <= 1'b0;
      pend_data  <= '0;
      pend_dp    <= '0;
      pend_blank <= '0;
      pend_lz    <= 1'b0;
      act_data   <= '0;
      act_dp     <= '0;
      act_blank  <= '1;
      act_lz     <= 1'b0;
    end else begin
      cnt        <= tick ? '0 : cnt + CNT_W'(1);
      if (tick)
        idx <= wrap ? '0 : idx + IDX_W'(1);
      frame_done <= wrap;
      if (wrap && pend) begin
        act_data  <= pend_data;
        act_dp    <= pend_dp;
        act_blank <= pend_blank;
        act_lz    <= pend_lz;
      end
      // A load on the wrap tick re-arms pending after the old content moves out.
      if (load) begin
        pend_data  <= data_in;
        pend_dp    <= dp_in;
        pend_blank <= blank_in;
        pend_lz    <= lz_en;
        pend       <= 1'b1;
      end else if (wrap) begin
        pend <= 1'b0;
      end
    end
  end

  always_comb begin
    nib       = 4'h0;
    dp_bit    = 1'b0;
    blank_bit = 1'b1;
    any_nz    = 1'b0;
    for (int j = 0; j < NUM_DIGITS; j++) begin
      if (IDX_W'(j) == idx) begin
        nib       = act_data[j*4 +: 4];
        dp_bit    = act_dp[j];
        blank_bit = act_blank[j];
      end
      if (j >= int'(idx) && act_data[j*4 +: 4] != 4'h0)
        any_nz = 1'b1;
    end
  end

  seg_hex_decode u_hex (
    .nibble  (nib),
    .pattern (hex_pat)
  );

  always_comb begin
    duty_thr = ((PW'(brightness) + PW'(1)) * PW'(CLK_DIV)) >> BRIGHT_W;
    lit_on   = PW'(cnt) < duty_thr;
    dark     = blank_bit || (act_lz && (idx != '0) && !any_nz);
    seg_nxt  = dark ? SEG_BLANK : {~dp_bit, hex_pat};
    an_nxt   = '1;
    for (int j = 0; j < NUM_DIGITS; j++)
      if (IDX_W'(j) == idx && !dark && lit_on)
        an_nxt[j] = 1'b0;
  end

  // Stage p1: registered segment/anode drive, one cycle behind cnt/idx
  always_ff @(posedge clk) begin
    if (rst) begin
      seg_p1 <= SEG_BLANK;
      an_p1  <= '1;
    end else begin
      seg_p1 <= seg_nxt;
      an_p1  <= an_nxt;
    end
  end

  assign seg_out  = seg_p1;
  assign an_out   = an_p1;
  assign pend_out = pend;

endmodule
